// File: rtl/serial_byte_deserializer_pkg.sv
// Shared types and constants for the framed serial-to-word deserializer.
// Optional feature macro: DESER_PARITY_EN (adds the PAR state).
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must be able to hold WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_byte_deserializer_if.sv
// Serial input, word output and status signals of the deserializer.
// With DESER_PARITY_EN defined the bundle also carries data_perr.
interface serial_byte_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             sin_valid;
  logic             sin_data;
  logic             sin_frame;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             clr_status;
  logic             overrun;
  logic             frame_err;
`ifdef DESER_PARITY_EN
  logic             data_perr;

  modport slave (
    input  sin_valid, sin_data, sin_frame, data_ready, clr_status,
    output data_out, data_valid, overrun, frame_err, data_perr
  );
  modport master (
    output sin_valid, sin_data, sin_frame, data_ready, clr_status,
    input  data_out, data_valid, overrun, frame_err, data_perr
  );
`else
  modport slave (
    input  sin_valid, sin_data, sin_frame, data_ready, clr_status,
    output data_out, data_valid, overrun, frame_err
  );
  modport master (
    output sin_valid, sin_data, sin_frame, data_ready, clr_status,
    input  data_out, data_valid, overrun, frame_err
  );
`endif
endinterface

// File: rtl/serial_byte_deserializer_out_reg.sv
// One-word output holding register with valid/ready handshake and sticky overrun.
// DESER_PARITY_EN adds a parity-error flag registered alongside the word.
module deser_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
`ifdef DESER_PARITY_EN
  input  logic             i_load_perr,
  output logic             o_perr,
`endif
  input  logic             i_ready,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_handshake;
  logic             w_accept;
`ifdef DESER_PARITY_EN
  logic             r_perr;
`endif

  assign w_handshake = r_valid & i_ready;
  // A new word fits if the register is empty or is being drained this cycle.
  assign w_accept    = i_load & (~r_valid | w_handshake);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef DESER_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_data  <= i_load_data;
        r_valid <= 1'b1;
`ifdef DESER_PARITY_EN
        r_perr  <= i_load_perr;
`endif
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end

      if (i_load && !w_accept)
        r_overrun <= 1'b1;
      else if (i_clr)
        r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
`ifdef DESER_PARITY_EN
  assign o_perr    = r_perr;
`endif
endmodule

// File: rtl/serial_byte_deserializer.sv
// Assembles a framed, MSB-first serial bit stream into WIDTH-bit words.
// DESER_PARITY_EN: each word is followed by an even-parity bit (PAR state).
module serial_byte_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_byte_deserializer_if.slave bus
);
  localparam int CW = count_width(WIDTH);

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic             r_frame_err, w_frame_err_next;
  logic             w_done;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_restart;
  logic [WIDTH-1:0] w_word;

  // Left shift: after WIDTH bits the first (framed) bit sits at WIDTH-1.
  assign w_shifted = {r_shift[WIDTH-2:0], bus.sin_data};
  assign w_restart = {{(WIDTH-1){1'b0}}, bus.sin_data};
`ifdef DESER_PARITY_EN
  logic w_perr;
  assign w_word = r_shift;
  assign w_perr = ^{r_shift, bus.sin_data};
`else
  assign w_word = w_shifted;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_shift_next     = r_shift;
    w_frame_err_next = 1'b0;
    w_done           = 1'b0;
    if (bus.sin_valid) begin
      case (r_state)
        IDLE: begin
          if (bus.sin_frame) begin
            w_shift_next = w_restart;
            w_count_next = CW'(1);
            w_state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sin_frame) begin
            w_frame_err_next = 1'b1;
            w_shift_next     = w_restart;
            w_count_next     = CW'(1);
          end else begin
            w_shift_next = w_shifted;
            if (r_count == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
              w_count_next = CW'(WIDTH);
              w_state_next = PAR;
`else
              w_count_next = '0;
              w_done       = 1'b1;
              w_state_next = IDLE;
`endif
            end else begin
              w_count_next = r_count + CW'(1);
            end
          end
        end
`ifdef DESER_PARITY_EN
        PAR: begin
          if (bus.sin_frame) begin
            w_frame_err_next = 1'b1;
            w_shift_next     = w_restart;
            w_count_next     = CW'(1);
            w_state_next     = SHIFT;
          end else begin
            w_count_next = '0;
            w_done       = 1'b1;
            w_state_next = IDLE;
          end
        end
`endif
        default: begin
          w_count_next = '0;
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign bus.frame_err = r_frame_err;

  deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_done),
    .i_load_data (w_word),
`ifdef DESER_PARITY_EN
    .i_load_perr (w_perr),
    .o_perr      (bus.data_perr),
`endif
    .i_ready     (bus.data_ready),
    .i_clr       (bus.clr_status),
    .o_data      (bus.data_out),
    .o_valid     (bus.data_valid),
    .o_overrun   (bus.overrun)
  );
endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Self-checking bench: directed scenarios plus a randomized run against a bit-counting model.
// Build with DESER_PARITY_EN defined to also exercise the parity bit and data_perr.
module tb_serial_byte_deserializer;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk;
  logic rst_n;
  serial_byte_deserializer_if #(.WIDTH(W)) bus ();

  serial_byte_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_cnt = 0;

  // Reference model: bits collected since the last frame, plus the held word.
  int         mcnt;
  int         mword;
  bit         exp_valid;
  logic [7:0] exp_data;
  bit         exp_ovr;
  bit         exp_ferr;
  bit         exp_perr;

  task automatic model_reset();
    mcnt = 0; mword = 0; exp_valid = 0; exp_data = 8'h00;
    exp_ovr = 0; exp_ferr = 0; exp_perr = 0;
  endtask

  task automatic step(input bit v, input bit d, input bit f, input bit rdy, input bit clr);
    bit comp;
    bit hs;
    int cword;
    bit cperr;
    bus.sin_valid  = v;
    bus.sin_data   = d;
    bus.sin_frame  = f;
    bus.data_ready = rdy;
    bus.clr_status = clr;
    comp = 0; cword = 0; cperr = 0; exp_ferr = 0;
    if (v) begin
      if (f) begin
        if (mcnt > 0) exp_ferr = 1;
        mword = int'(d);
        mcnt  = 1;
      end else if (mcnt > 0) begin
        mword = mword * 2 + int'(d);
        mcnt++;
      end
      if (mcnt == NB) begin
        comp = 1;
        mcnt = 0;
`ifdef DESER_PARITY_EN
        cword = mword / 2;
        cperr = ($countones(mword) % 2) == 1;
`else
        cword = mword;
`endif
      end
    end
    hs = exp_valid && rdy;
    if (comp && exp_valid && !rdy) exp_ovr = 1;
    else if (clr) exp_ovr = 0;
    if (comp && (!exp_valid || hs)) begin
      exp_valid = 1;
      exp_data  = cword[7:0];
      exp_perr  = cperr;
    end else if (hs) begin
      exp_valid = 0;
    end
    @(posedge clk);
    #1;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  endtask

  // Sends one word MSB first with sin_frame on its first bit; par_flip corrupts the parity bit.
  task automatic send_word(input logic [7:0] w, input int gap, input bit rdy,
                           input bit rdy_last, input bit par_flip);
    logic [7:0] wv;
    bit b;
    bit last;
    wv = w;
    for (int i = 0; i < NB; i++) begin
      if (i < W) b = wv[7-i];
      else       b = (^wv) ^ par_flip;
      last = (i == NB - 1);
      step(1'b1, b, i == 0, last ? rdy_last : rdy, 1'b0);
      if (!last)
        for (int g = 0; g < gap; g++)
          step(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sin_valid = 0; bus.sin_data = 0; bus.sin_frame = 0;
    bus.data_ready = 0; bus.clr_status = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.data_valid); end
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.data_out); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b want 0", bus.overrun); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %0b want 0", bus.frame_err); end
    rst_n = 1'b1;
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", bus.data_valid); end
    n_tests++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", bus.data_out); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %0b want 0", bus.data_valid); end
    $display("[TB] basic word a5 delivered");
  endtask

  task automatic test_gaps();
    ferr_cnt = 0;
    send_word(8'hA5, 3, 1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_data got %h/%0b want a5/1", bus.data_out, bus.data_valid); end
    n_tests++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL gaps_frame_err got %0d pulses want 0", ferr_cnt); end
    step(0, 0, 0, 1, 0);
    $display("[TB] gapped word a5 delivered");
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first got %h/%0b want 3c/1", bus.data_out, bus.data_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %0b want 0", bus.overrun); end
    send_word(8'hC3, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.data_out !== 8'h3C) begin n_fail++; $display("FAIL ovr_held got %h want 3c", bus.data_out); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b want 1", bus.overrun); end
    step(0, 0, 0, 0, 1);
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b want 0", bus.overrun); end
    n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_still_valid got %0b want 1", bus.data_valid); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got %0b want 0", bus.data_valid); end
    $display("[TB] overrun word c3 dropped, 3c held");
  endtask

  task automatic test_frame_err();
    logic [7:0] part;
    part = 8'h5A;
    ferr_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, part[7-i], i == 0, 1'b1, 1'b0);
    send_word(8'hFF, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt); end
    n_tests++; if (bus.data_out !== 8'hFF || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_word got %h/%0b want ff/1", bus.data_out, bus.data_valid); end
    step(0, 0, 0, 1, 0);
    $display("[TB] frame error on bit 5, word ff delivered");
  endtask

  task automatic test_frame_last();
    logic [7:0] tail;
    tail = 8'hB3;
    ferr_cnt = 0;
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b0, i == 0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL flast_pulse got %0b want 1", bus.frame_err); end
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL flast_no_word got %0b want 0", bus.data_valid); end
    for (int i = 1; i < W; i++) step(1'b1, tail[7-i], 1'b0, 1'b1, 1'b0);
`ifdef DESER_PARITY_EN
    step(1'b1, ^tail, 1'b0, 1'b1, 1'b0);
`endif
    n_tests++; if (bus.data_out !== 8'hB3 || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL flast_restart got %h/%0b want b3/1", bus.data_out, bus.data_valid); end
    n_tests++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL flast_pulses got %0d want 1", ferr_cnt); end
    step(0, 0, 0, 1, 0);
    $display("[TB] frame on last bit, restarted word b3 delivered");
  endtask

  task automatic test_back_to_back();
    send_word(8'h7E, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.data_out !== 8'h7E) begin n_fail++; $display("FAIL b2b_hold got %h want 7e", bus.data_out); end
    send_word(8'h81, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h81) begin n_fail++; $display("FAIL b2b_data got %h want 81", bus.data_out); end
    n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %0b want 1", bus.data_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %0b want 0", bus.overrun); end
    step(0, 0, 0, 1, 0);
    $display("[TB] handshake and completion same cycle, 81 loaded");
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.data_perr !== 1'b0 || bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL par_good got %0b/%h want 0/a5", bus.data_perr, bus.data_out); end
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.data_perr !== 1'b1 || bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL par_bad got %0b/%h want 1/a5", bus.data_perr, bus.data_out); end
    step(0, 0, 0, 1, 0);
    $display("[TB] parity good and bad words checked");
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] part;
    part = 8'h96;
    send_word(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, part[7-i], i == 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    n_tests++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_out got %h/%0b want 00/0", bus.data_out, bus.data_valid); end
    n_tests++; if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got %0b/%0b want 0/0", bus.overrun, bus.frame_err); end
`ifdef DESER_PARITY_EN
    n_tests++; if (bus.data_perr !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr got %0b want 0", bus.data_perr); end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_after got %h/%0b want a5/1", bus.data_out, bus.data_valid); end
    step(0, 0, 0, 1, 0);
    $display("[TB] reset mid-word cleared outputs");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
           1'($urandom), $urandom_range(0, 15) == 0);
      n_tests++;
      if (bus.data_valid !== exp_valid || bus.overrun !== exp_ovr || bus.frame_err !== exp_ferr ||
          (exp_valid && bus.data_out !== exp_data)) begin
        n_fail++; bad++;
        if (bad <= 10)
          $display("FAIL random cyc %0d got v=%0b d=%h o=%0b fe=%0b want v=%0b d=%h o=%0b fe=%0b",
                   c, bus.data_valid, bus.data_out, bus.overrun, bus.frame_err,
                   exp_valid, exp_data, exp_ovr, exp_ferr);
      end
`ifdef DESER_PARITY_EN
      if (exp_valid) begin
        n_tests++;
        if (bus.data_perr !== exp_perr) begin
          n_fail++; bad++;
          if (bad <= 10) $display("FAIL random_perr cyc %0d got %0b want %0b", c, bus.data_perr, exp_perr);
        end
      end
`endif
    end
    $display("[TB] random run of 600 cycles done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_frame_err();
    test_frame_last();
    test_back_to_back();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
